// File: rtl/ecc_codec_apb_if.sv
// APB3 zero-wait bus bundle for the ECC codec register file.
interface ecc_codec_apb_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) ();
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA
    );
endinterface

// File: rtl/ecc_codec_apb.sv
// Extended-Hamming SECDED encoder/decoder for 8/16/32-bit codewords, driven by an
// APB register file; supports encode, decode and encode->noise->decode channel runs.
module ecc_codec_apb #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_codec_apb_if.slave        apb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors
);

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'('h00);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'('h04);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'('h08);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'('h0C);

    localparam logic [1:0] OP_ENCODE = 2'd0;
    localparam logic [1:0] OP_DECODE = 2'd1;
    localparam logic [1:0] OP_FULL   = 2'd2;

    typedef enum logic [1:0] {IDLE, CALC, CALC2, DONE} state_t;

    // Codeword bit k sits at Hamming position k; positions >= n are forced to zero.
    function automatic logic [31:0] hamming_encode(input logic [31:0] info, input logic [5:0] n);
        logic [31:0] cw;
        logic [4:0]  j;
        logic        p;
        cw = '0;
        j  = '0;
        for (int k = 3; k < 32; k++) begin
            if (6'(k) < n && (k & (k - 1)) != 0) begin
                cw[k] = info[j];
                j     = j + 5'd1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            p = 1'b0;
            for (int k = 1; k < 32; k++) begin
                if (6'(k) < n && k[i]) p = p ^ cw[k];
            end
            if (6'(1 << i) < n) cw[1 << i] = p;
        end
        p = 1'b0;
        for (int k = 1; k < 32; k++) begin
            if (6'(k) < n) p = p ^ cw[k];
        end
        cw[0] = p;
        return cw;
    endfunction

    // Returns {error_count[1:0], info[25:0]}; double errors leave the info uncorrected.
    function automatic logic [27:0] hamming_decode(input logic [31:0] cw_in, input logic [5:0] n);
        logic [31:0] cw;
        logic [31:0] info;
        logic [4:0]  s;
        logic [4:0]  j;
        logic        p;
        logic [1:0]  errs;
        cw   = cw_in;
        info = '0;
        s    = '0;
        j    = '0;
        p    = 1'b0;
        errs = 2'd0;
        for (int k = 0; k < 32; k++) begin
            if (6'(k) < n && cw[k]) begin
                p = ~p;
                s = s ^ 5'(k);
            end
        end
        if (p) begin
            errs  = 2'd1;
            cw[s] = ~cw[s];
        end else if (s != 5'd0) begin
            errs = 2'd2;
        end
        for (int k = 3; k < 32; k++) begin
            if (6'(k) < n && (k & (k - 1)) != 0) begin
                info[j] = cw[k];
                j       = j + 5'd1;
            end
        end
        return {errs, info[25:0]};
    endfunction

    state_t                 state_q;
    logic [1:0]             ctrl_q;
    logic [1:0]             width_q;
    logic [AMBA_WORD-1:0]   data_in_q;
    logic [AMBA_WORD-1:0]   noise_q;
    logic [AMBA_WORD-1:0]   prdata_q;
    logic [31:0]            cw_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [1:0]             errs_q;
    logic                   done_q;

    logic [5:0]             n_bits;
    logic [31:0]            width_mask;
    logic [31:0]            data_in_ext;
    logic [31:0]            noise_ext;
    logic [31:0]            enc_cw;
    logic [31:0]            dec_src;
    logic [27:0]            dec_res;
    logic [31:0]            dec_info;
    logic [AMBA_WORD-1:0]   prdata_d;
    logic                   wr_commit;
    logic                   rd_setup;
    logic                   accept_wr;
    logic                   ctrl_ok;
    logic                   width_ok;

    assign n_bits = 6'd8 << width_q;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_mask
            assign width_mask[gi] = (6'(gi) < n_bits);
        end
    endgenerate

    assign data_in_ext = 32'(data_in_q);
    assign noise_ext   = 32'(noise_q);
    assign wr_commit   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_setup    = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    // DONE is not busy, so a CTRL write landing there chains the next operation.
    assign accept_wr   = (state_q == IDLE) || (state_q == DONE);
    assign ctrl_ok     = apb.PWDATA[1:0] != 2'd3;
    assign width_ok    = (apb.PWDATA[1:0] != 2'd3) && ((8 << int'(apb.PWDATA[1:0])) <= DATA_WIDTH);

    always_comb begin
        enc_cw   = hamming_encode(data_in_ext, n_bits);
        dec_src  = (state_q == CALC2) ? cw_q : data_in_ext;
        dec_res  = hamming_decode(dec_src, n_bits);
        dec_info = {6'd0, dec_res[25:0]};
        prdata_d = '0;
        case (apb.PADDR)
            ADDR_CTRL:  prdata_d = AMBA_WORD'(ctrl_q);
            ADDR_DATA:  prdata_d = data_in_q;
            ADDR_WIDTH: prdata_d = AMBA_WORD'(width_q);
            ADDR_NOISE: prdata_d = noise_q;
            default:    prdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            width_q    <= '0;
            data_in_q  <= '0;
            noise_q    <= '0;
            prdata_q   <= '0;
            cw_q       <= '0;
            data_out_q <= '0;
            errs_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rd_setup) prdata_q <= prdata_d;

            if (wr_commit && accept_wr) begin
                case (apb.PADDR)
                    ADDR_CTRL:  if (ctrl_ok) ctrl_q <= apb.PWDATA[1:0];
                    ADDR_DATA:  data_in_q <= apb.PWDATA;
                    ADDR_WIDTH: if (width_ok) width_q <= apb.PWDATA[1:0];
                    ADDR_NOISE: noise_q <= apb.PWDATA;
                    default: ;
                endcase
            end

            case (state_q)
                IDLE, DONE: begin
                    if (wr_commit && apb.PADDR == ADDR_CTRL && ctrl_ok) state_q <= CALC;
                    else                                                state_q <= IDLE;
                end
                CALC: begin
                    case (ctrl_q)
                        OP_ENCODE: begin
                            data_out_q <= enc_cw[DATA_WIDTH-1:0];
                            errs_q     <= 2'd0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                        OP_DECODE: begin
                            data_out_q <= dec_info[DATA_WIDTH-1:0];
                            errs_q     <= dec_res[27:26];
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                        OP_FULL: begin
                            cw_q    <= enc_cw ^ (noise_ext & width_mask);
                            state_q <= CALC2;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
                CALC2: begin
                    data_out_q <= dec_info[DATA_WIDTH-1:0];
                    errs_q     <= dec_res[27:26];
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign apb.PRDATA     = prdata_q;
    assign data_out       = data_out_q;
    assign num_of_errors  = errs_q;
    assign operation_done = done_q;

endmodule

// File: tb/tb_ecc_codec_apb.sv
// Self-checking bench for ecc_codec_apb: directed vector table, reference-model
// randomized runs and hand-written multi-cycle sequences (busy, back-to-back, reset).
module tb_ecc_codec_apb;

    logic        clk;
    logic        rst;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int vectors;
    int miscompares;

    ecc_codec_apb_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) bus ();

    ecc_codec_apb #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .apb            (bus),
        .data_out       (data_out),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [1:0]  wcode;
        logic [31:0] data;
        logic [31:0] noise;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Reference model: syndrome-based encoding (parity bits equal the syndrome of
    // the info-only word) and textbook SECDED decoding.
    function automatic logic [31:0] wmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic logic [31:0] model_encode(input logic [31:0] info, input int n);
        logic [31:0] cw;
        int j;
        int syn;
        cw = '0;
        j = 0;
        syn = 0;
        for (int p = 1; p < n; p++)
            if ((p & (p - 1)) != 0) begin cw[p] = info[j]; j++; end
        for (int p = 1; p < n; p++) if (cw[p]) syn = syn ^ p;
        for (int i = 0; (1 << i) < n; i++) cw[1 << i] = syn[i];
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [33:0] model_decode(input logic [31:0] cw_in, input int n);
        logic [31:0] cw;
        logic [31:0] info;
        int syn;
        int par;
        int errs;
        int j;
        cw = cw_in & wmask(n);
        syn = 0;
        for (int p = 1; p < n; p++) if (cw[p]) syn = syn ^ p;
        par = ^cw;
        errs = 0;
        if (par == 1) begin errs = 1; cw[syn] = ~cw[syn]; end
        else if (syn != 0) errs = 2;
        info = '0;
        j = 0;
        for (int p = 1; p < n; p++)
            if ((p & (p - 1)) != 0) begin info[j] = cw[p]; j++; end
        return {2'(errs), info};
    endfunction

    // All APB tasks start and end #1 after a rising edge.
    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
        bus.PADDR = addr; bus.PWDATA = data; bus.PWRITE = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
        bus.PADDR = addr; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        data = bus.PRDATA;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    // Commits a CTRL write and measures cycles from commit until operation_done.
    task automatic start_and_wait(input logic [1:0] ctrl, input int exp_lat, input string name);
        int lat;
        apb_write(20'h00, {30'd0, ctrl});
        lat = 1;
        while (!operation_done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!operation_done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: operation_done never seen, required within %0d cycles", name, exp_lat);
        end else begin
            chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        apb_write(20'h08, {30'd0, v.wcode});
        apb_write(20'h04, v.data);
        apb_write(20'h0C, v.noise);
        start_and_wait(v.ctrl, v.exp_lat, name);
        chk({name, "_data"}, data_out, v.exp_data);
        chk({name, "_errs"}, 32'(num_of_errors), 32'(v.exp_err));
        @(posedge clk); #1;
        chk({name, "_pulse"}, 32'(operation_done), 32'd0);
    endtask

    vec_t        tbl[13];
    vec_t        v;
    logic [31:0] rd;
    logic [33:0] mres;
    int          highs;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_done", 32'(operation_done), 32'd0);
        chk("reset_errs", 32'(num_of_errors), 32'd0);
        chk("reset_prdata", bus.PRDATA, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //         ctrl  w   data          noise         exp_data      err lat
        tbl[0]  = '{2'd0, 2'd0, 32'h0000_000B, 32'h0,        32'h0000_00AA, 2'd0, 2};
        tbl[1]  = '{2'd1, 2'd0, 32'h0000_008A, 32'h0,        32'h0000_000B, 2'd1, 2};
        tbl[2]  = '{2'd1, 2'd0, 32'h0000_00AB, 32'h0,        32'h0000_000B, 2'd1, 2};
        tbl[3]  = '{2'd1, 2'd0, 32'h0000_008B, 32'h0,        32'h0000_0009, 2'd2, 2};
        tbl[4]  = '{2'd2, 2'd0, 32'h0000_000B, 32'h00,       32'h0000_000B, 2'd0, 3};
        tbl[5]  = '{2'd2, 2'd0, 32'h0000_000B, 32'h20,       32'h0000_000B, 2'd1, 3};
        tbl[6]  = '{2'd2, 2'd0, 32'h0000_000B, 32'h21,       32'h0000_0009, 2'd2, 3};
        tbl[7]  = '{2'd1, 2'd0, 32'h0000_00AA, 32'h0,        32'h0000_000B, 2'd0, 2};
        tbl[8]  = '{2'd0, 2'd0, 32'hFFFF_FFF0, 32'h0,        32'h0000_0000, 2'd0, 2};
        tbl[9]  = '{2'd1, 2'd0, 32'hFFFF_FFAA, 32'h0,        32'h0000_000B, 2'd0, 2};
        tbl[10] = '{2'd0, 2'd1, 32'h0000_07FF, 32'h0,        32'h0000_FFFF, 2'd0, 2};
        tbl[11] = '{2'd2, 2'd1, 32'h0000_07FF, 32'hFFFF_0000, 32'h0000_07FF, 2'd0, 3};
        tbl[12] = '{2'd0, 2'd2, 32'h03FF_FFFF, 32'h0,        32'hFFFF_FFFF, 2'd0, 2};
        for (int i = 0; i < 13; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

        // Width 32, every single-bit noise position must be corrected.
        v.data = $urandom & 32'h03FF_FFFF;
        for (int b = 0; b < 32; b++) begin
            v.ctrl = 2'd2; v.wcode = 2'd2; v.noise = 32'h1 << b;
            v.exp_data = v.data; v.exp_err = 2'd1; v.exp_lat = 3;
            do_op(v, $sformatf("single_bit%0d", b));
        end

        // Randomized operations against the reference model.
        for (int r = 0; r < 40; r++) begin
            int n;
            int kind;
            int b0;
            int b1;
            v.ctrl  = 2'($urandom_range(0, 2));
            v.wcode = 2'($urandom_range(0, 2));
            n = 8 << v.wcode;
            kind = $urandom_range(0, 2);
            b0 = $urandom_range(0, n - 1);
            b1 = (b0 + $urandom_range(1, n - 1)) % n;
            v.noise = (kind == 0) ? 32'h0 : (kind == 1) ? (32'h1 << b0) : ((32'h1 << b0) | (32'h1 << b1));
            v.noise = v.noise | ($urandom & ~wmask(n));
            v.data = $urandom;
            if (v.ctrl == 2'd1) v.data = (model_encode(v.data, n) ^ v.noise) | ($urandom & ~wmask(n));
            if (v.ctrl == 2'd0) begin
                v.exp_data = model_encode(v.data, n);
                v.exp_err = 2'd0;
                v.exp_lat = 2;
            end else begin
                if (v.ctrl == 2'd1) mres = model_decode(v.data, n);
                else                mres = model_decode(model_encode(v.data, n) ^ v.noise, n);
                v.exp_data = mres[31:0];
                v.exp_err = mres[33:32];
                v.exp_lat = (v.ctrl == 2'd2) ? 3 : 2;
            end
            do_op(v, $sformatf("rand%0d_m%0d_w%0d", r, v.ctrl, n));
        end

        // DATA_IN write during BUSY is dropped; the running op uses the old data.
        apb_write(20'h08, 32'd2);
        apb_write(20'h04, 32'h0123_4567);
        apb_write(20'h0C, 32'h0000_0100);
        apb_write(20'h00, 32'd2);
        apb_write(20'h04, 32'h0000_0055);
        highs = 0;
        for (int c = 0; c < 4 && !operation_done; c++) begin @(posedge clk); #1; end
        chk("busy_done_seen", 32'(operation_done), 32'd1);
        chk("busy_data", data_out, 32'h0123_4567 & 32'h03FF_FFFF);
        chk("busy_errs", 32'(num_of_errors), 32'd1);
        @(posedge clk); #1;
        apb_read(20'h04, rd);
        chk("busy_readback", rd, 32'h0123_4567);

        // Back-to-back: second CTRL write commits in the DONE cycle of the first.
        apb_write(20'h08, 32'd0);
        apb_write(20'h04, 32'h0000_000B);
        apb_write(20'h00, 32'd0);
        chk("b2b_calc_low", 32'(operation_done), 32'd0);
        bus.PADDR = 20'h00; bus.PWDATA = 32'd1; bus.PWRITE = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        chk("b2b_first_done", 32'(operation_done), 32'd1);
        chk("b2b_first_data", data_out, 32'h0000_00AA);
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        chk("b2b_gap_low", 32'(operation_done), 32'd0);
        chk("b2b_hold_data", data_out, 32'h0000_00AA);
        @(posedge clk); #1;
        chk("b2b_second_done", 32'(operation_done), 32'd1);
        chk("b2b_second_data", data_out, 32'h0000_0001);
        chk("b2b_second_errs", 32'(num_of_errors), 32'd1);
        @(posedge clk); #1;

        // Illegal CTRL/width values and unmapped addresses.
        apb_write(20'h00, 32'd3);
        highs = 0;
        for (int c = 0; c < 5; c++) begin if (operation_done) highs++; @(posedge clk); #1; end
        chk("ctrl3_no_op", 32'(highs), 32'd0);
        apb_read(20'h00, rd);
        chk("ctrl3_readback", rd, 32'd1);
        apb_write(20'h08, 32'd1);
        apb_write(20'h08, 32'd3);
        apb_read(20'h08, rd);
        chk("width3_readback", rd, 32'd1);
        apb_write(20'h10, 32'hDEAD_BEEF);
        apb_read(20'h10, rd);
        chk("unmapped_read", rd, 32'd0);
        apb_read(20'h0C, rd);
        chk("noise_readback", rd, 32'h0000_0100);

        // Reset one cycle after a CTRL commit aborts the operation.
        apb_write(20'h04, 32'h0000_0F0F);
        apb_write(20'h00, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        highs = 0;
        for (int c = 0; c < 5; c++) begin if (operation_done) highs++; @(posedge clk); #1; end
        chk("rst_abort_done", 32'(highs), 32'd0);
        chk("rst_abort_data", data_out, 32'd0);
        chk("rst_abort_errs", 32'(num_of_errors), 32'd0);
        apb_read(20'h00, rd); chk("rst_ctrl_reg", rd, 32'd0);
        apb_read(20'h04, rd); chk("rst_data_reg", rd, 32'd0);
        apb_read(20'h08, rd); chk("rst_width_reg", rd, 32'd0);
        apb_read(20'h0C, rd); chk("rst_noise_reg", rd, 32'd0);

        // Reset wins over a write committing on the same edge.
        bus.PADDR = 20'h04; bus.PWDATA = 32'h0000_1234; bus.PWRITE = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        apb_read(20'h04, rd);
        chk("rst_priority", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
